ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction-fetch front end of the single-cycle-derived CPU31 core: owns the program counter, drives the instruction memory address, and queues fetched words with their PC into a 2-entry buffer. It presents them to decode over a valid/ready handshake and accepts redirects (branch, jump, exception vector) from execute. The memory side is the asynchronous-read instruction ROM: 11-bit word address in, 32-bit instruction out in the same cycle.

## Interface
- TEXT_BASE, 32'h0040_0000, byte address mapped to IMEM word 0; reset PC.
- ADDR_W, 11, IMEM word-address width (2048 words).
- clk  input  1  core clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  ADDR_W  IMEM word address = (pc - TEXT_BASE)[ADDR_W+1:2].
- imem_instr  input  32  IMEM read data, valid combinationally for imem_addr.
- out_valid  output  1  buffer head holds a fetched instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  32  head instruction.
- out_pc  output  32  byte PC of head instruction.
- redirect  input  1  load new PC, flush buffer.
- redirect_pc  input  32  target byte address.
- fault  output  1  fetch stopped on a bad PC.

## Operation
- State machine: RUN, FAULT. Reset -> RUN, pc = TEXT_BASE, buffer empty.
- RUN, no redirect: if buffer not full, or full with a dequeue this cycle, enqueue {pc, imem_instr} and pc <= pc + 4; otherwise pc holds.
- Dequeue when out_valid && out_ready; head advances. Enqueue and dequeue may coincide at any occupancy.
- Redirect (any state) has priority over everything: buffer flushed (including the head being handed over that cycle — decode must treat it as squashed), no enqueue, pc <= redirect_pc.
- Bad PC: redirect_pc[1:0] != 0 or (redirect_pc - TEXT_BASE) >= 4*2^ADDR_W (unsigned). On redirect to a bad PC -> FAULT. Sequential fetch reaching the end of the range also -> FAULT (no wrap); the last in-range word is still enqueued.
- FAULT: no enqueues, buffered entries still drain normally, fault = 1. Leaves only via redirect to a good PC (-> RUN) or rst.
- imem_addr is driven from pc in every state; the low 2 bits and out-of-range high bits are dropped.

## Timing
- Reset values: out_valid 0, out_instr 0, out_pc 0, fault 0, imem_addr 0.
- Fetch latency: instruction at pc visible on out_* one cycle after the enqueue edge; first out_valid on the first edge after rst deasserts.
- Sustained throughput: one instruction per cycle while out_ready = 1.
- Redirect in cycle N: out_valid = 0 in cycle N+1; target instruction valid in cycle N+2.
- fault rises the cycle after entering FAULT and falls the cycle after a good redirect.
- Buffer full with out_ready = 0: pc and imem_addr hold, entries stable.

## Configuration
- IFETCH_STATS_EN defined: adds output fetch_cnt (32 bits, reset 0, +1 per enqueue, wraps) and redirect_cnt (16 bits, reset 0, +1 per redirect, saturates at 16'hFFFF).
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package cpu31_pkg: TEXT_BASE, INSTR_W = 32, NOP_INSTR = 32'h0, fetch-state enum.
- One sub-module: fetch_fifo, 2-entry {pc, instr} queue with push/pop/flush, full/empty, simultaneous push+pop at full allowed.
- ifetch_unit holds the PC, state machine, range check and optional counters.

## Test plan
- Reset release, IMEM words 0..3 = 0x11,0x22,0x33,0x44, out_ready = 1 -> out_pc 0x00400000..0x0040000C with matching instr on consecutive cycles.
- out_ready = 0 for 5 cycles -> buffer holds 2 entries (PCs 0x00400000, 0x00400004), pc stalls at 0x00400008; release -> in-order drain, no loss or duplicate.
- Redirect to 0x00400100 while buffer full -> out_valid 0 next cycle, then out_pc 0x00400100 with IMEM word 64.
- Redirect to 0x00400102 -> fault = 1, no new entries; redirect to 0x00400000 -> fault = 0, fetch resumes.
- Redirect to 0x00401FFC -> word 2047 delivered, then fault = 1; rst mid-stream -> all outputs return to reset values immediately.
- With IFETCH_STATS_EN: 10 enqueues and 3 redirects -> fetch_cnt = 10, redirect_cnt = 3.

Source files
------------

// File: rtl/cpu31_pkg.sv
// Shared CPU31 fetch definitions: text-segment base, IMEM geometry, fetch state
// and the {pc, instr} entry carried through the fetch buffer.
package cpu31_pkg;

   localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
   localparam int          ADDR_W    = 11;
   localparam int          INSTR_W   = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      S_RUN,
      S_FAULT
   } fetch_state_e;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // A PC is fetchable when word aligned and inside the 2^ADDR_W-word text window.
   function automatic logic pc_is_good(input logic [31:0] pc);
      logic [31:0] off;
      off = pc - TEXT_BASE;
      return (off[1:0] == 2'b00) && (off[31:ADDR_W+2] == '0);
   endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// fetch_fifo: 2-entry {pc, instr} queue with push/pop/flush; push and pop may
// coincide at any occupancy, including full.
module fetch_fifo
   import cpu31_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t din_i,
   output fetch_entry_t head_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [1:0]   count_q;
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   fetch_entry_t mem_q [2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         // NOTE: storage is reset only because the head drives out_pc/out_instr, which must read 0 in reset.
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
         end
      end else if (flush_i) begin
         count_q  <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere here so push and pop both see the pre-edge pointers.
         if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(push_i) - 2'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: CPU31 fetch front end -- PC, RUN/FAULT FSM, range check, 2-entry buffer.
// Optional fetch/redirect statistics counters are built when IFETCH_STATS_EN is defined.
module ifetch_unit
   import cpu31_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [31:0]        out_pc,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               fault
`ifdef IFETCH_STATS_EN
   ,
   output logic [31:0]        fetch_cnt,
   output logic [15:0]        redirect_cnt
`endif
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  pc_d;
   logic         fault_q;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   fetch_entry_t head;

   assign pc_d = pc_q + 32'd4;
   assign pop  = !empty && out_ready;
   // A full buffer still accepts a new word when its head leaves in the same cycle.
   assign push = (state_q == S_RUN) && !redirect && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RUN;
         pc_q    <= TEXT_BASE;
         fault_q <= 1'b0;
      end else if (redirect) begin
         pc_q <= redirect_pc;
         if (pc_is_good(redirect_pc)) begin
            state_q <= S_RUN;
            fault_q <= 1'b0;
         end else begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
         end
      end else if (push) begin
         pc_q <= pc_d;
         if (!pc_is_good(pc_d)) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
         end
      end
   end

   fetch_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect),
      .din_i   ('{pc: pc_q, instr: imem_instr}),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign imem_addr = ADDR_W'((pc_q - TEXT_BASE) >> 2);
   assign out_valid = !empty;
   assign out_instr = head.instr;
   assign out_pc    = head.pc;
   assign fault     = fault_q;

`ifdef IFETCH_STATS_EN
   logic [31:0] fetch_cnt_q;
   logic [15:0] redirect_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         if (push) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (redirect && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_q <= redirect_cnt_q + 16'd1;
         end
      end
   end

   assign fetch_cnt    = fetch_cnt_q;
   assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_ifetch_unit;

   localparam logic [31:0] TB_BASE  = 32'h0040_0000;
   localparam logic [31:0] TB_SPAN  = 32'h0000_2000;

   logic        clk;
   logic        rst;
   logic [10:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fault;
`ifdef IFETCH_STATS_EN
   logic [31:0] fetch_cnt;
   logic [15:0] redirect_cnt;
`endif

   logic [31:0] rom [2048];
   assign imem_instr = rom[imem_addr];

   ifetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fault       (fault)
`ifdef IFETCH_STATS_EN
      ,
      .fetch_cnt    (fetch_cnt),
      .redirect_cnt (redirect_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } m_ent_t;

   m_ent_t      mq [$];
   logic [31:0] mpc;
   logic        mfault;
   int unsigned mfetch;
   int unsigned mredir;
   int          n_vec  = 0;
   int          n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic good_pc(input logic [31:0] p);
      return (p[1:0] == 2'b00) && ((p - TB_BASE) < TB_SPAN);
   endfunction

   function automatic logic [10:0] word_of(input logic [31:0] p);
      logic [31:0] off;
      off = p - TB_BASE;
      return off[12:2];
   endfunction

   task automatic model_reset();
      mq.delete();
      mpc    = TB_BASE;
      mfault = 1'b0;
      mfetch = 0;
      mredir = 0;
   endtask

   task automatic compare_all();
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         check("out_pc", out_pc, mq[0].pc);
         check("out_instr", out_instr, mq[0].instr);
      end
      check("fault", 32'(fault), 32'(mfault));
      check("imem_addr", 32'(imem_addr), 32'(word_of(mpc)));
`ifdef IFETCH_STATS_EN
      check("fetch_cnt", fetch_cnt, mfetch);
      check("redirect_cnt", 32'(redirect_cnt), mredir);
`endif
   endtask

   // Drives one cycle of inputs (called at a falling edge), advances the model
   // across the next rising edge, then compares at the following falling edge.
   task automatic tick(input logic rdy, input logic rd, input logic [31:0] rpc);
      out_ready   = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      if (rd) begin
         mq.delete();
         mpc    = rpc;
         mfault = !good_pc(rpc);
         if (mredir < 32'hFFFF) mredir++;
      end else begin
         if (mq.size() > 0 && rdy) void'(mq.pop_front());
         if (!mfault && mq.size() < 2) begin
            mq.push_back('{pc: mpc, instr: rom[word_of(mpc)]});
            mfetch++;
            mpc = mpc + 32'd4;
            if ((mpc - TB_BASE) >= TB_SPAN) mfault = 1'b1;
         end
      end
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_instr"}, out_instr, 32'd0);
      check({tag, "_pc"}, out_pc, 32'd0);
      check({tag, "_fault"}, 32'(fault), 32'd0);
      check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
   endtask

   task automatic mid_reset();
      out_ready = 1'b0;
      redirect  = 1'b0;
      #2 rst = 1'b1;
      #1 check_reset_values("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rand_target();
      case ($urandom_range(0, 9))
         0:       return TB_BASE + ($urandom_range(0, 2047) << 2) + $urandom_range(1, 3);
         1:       return TB_BASE + TB_SPAN + ($urandom_range(0, 255) << 2);
         2:       return TB_BASE - ($urandom_range(1, 64) << 2);
         3, 4:    return TB_BASE + TB_SPAN - ($urandom_range(1, 4) << 2);
         default: return TB_BASE + ($urandom_range(0, 2047) << 2);
      endcase
   endfunction

   initial begin
      rst         = 1'b1;
      out_ready   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      for (int i = 0; i < 2048; i++) rom[i] = $urandom;
      rom[0]    = 32'h0000_0011;
      rom[1]    = 32'h0000_0022;
      rom[2]    = 32'h0000_0033;
      rom[3]    = 32'h0000_0044;
      rom[64]   = 32'hCAFE_0040;
      rom[2047] = 32'hDEAD_07FF;
      model_reset();

      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // Streaming from reset, one instruction per cycle.
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0, '0);
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_pc", out_pc, TB_BASE + 32'(4 * i));
         check("stream_instr", out_instr, 32'(8'h11 * (i + 1)));
      end

      // Stall: buffer fills with two entries, pc parks two words ahead.
      tick(1'b0, 1'b1, TB_BASE);
      check("redir_gap", 32'(out_valid), 32'd0);
      repeat (5) tick(1'b0, 1'b0, '0);
      check("stall_pc", out_pc, 32'h0040_0000);
      check("stall_addr", 32'(imem_addr), 32'd2);
      tick(1'b1, 1'b0, '0);
      check("drain0", out_pc, 32'h0040_0004);
      tick(1'b1, 1'b0, '0);
      check("drain1", out_pc, 32'h0040_0008);

      // Redirect while full.
      repeat (3) tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b1, 32'h0040_0100);
      check("redir_full_gap", 32'(out_valid), 32'd0);
      tick(1'b1, 1'b0, '0);
      check("redir_tgt_pc", out_pc, 32'h0040_0100);
      check("redir_tgt_instr", out_instr, 32'hCAFE_0040);

      // Misaligned target faults; good target recovers.
      tick(1'b1, 1'b1, 32'h0040_0102);
      check("bad_fault", 32'(fault), 32'd1);
      repeat (3) tick(1'b1, 1'b0, '0);
      check("bad_noenq", 32'(out_valid), 32'd0);
      tick(1'b1, 1'b1, TB_BASE);
      check("recover_fault", 32'(fault), 32'd0);
      tick(1'b1, 1'b0, '0);
      check("recover_pc", out_pc, TB_BASE);
      check("recover_instr", out_instr, 32'h0000_0011);

      // End of text window: last word delivered, then fault, no wrap.
      tick(1'b1, 1'b1, 32'h0040_1FFC);
      tick(1'b1, 1'b0, '0);
      check("end_pc", out_pc, 32'h0040_1FFC);
      check("end_instr", out_instr, 32'hDEAD_07FF);
      check("end_fault", 32'(fault), 32'd1);
      tick(1'b1, 1'b0, '0);
      check("end_nowrap", 32'(out_valid), 32'd0);

      // Entries queued before the fault still drain.
      tick(1'b0, 1'b1, 32'h0040_1FF8);
      repeat (3) tick(1'b0, 1'b0, '0);
      check("fault_full_valid", 32'(out_valid), 32'd1);
      check("fault_full_pc", out_pc, 32'h0040_1FF8);
      tick(1'b1, 1'b0, '0);
      check("fault_drain_pc", out_pc, 32'h0040_1FFC);
      tick(1'b1, 1'b0, '0);
      check("fault_drained", 32'(out_valid), 32'd0);

      mid_reset();

`ifdef IFETCH_STATS_EN
      repeat (10) tick(1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, TB_BASE + 32'(16 * i));
      check("stats_fetch", fetch_cnt, 32'd10);
      check("stats_redir", 32'(redirect_cnt), 32'd3);
`endif

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            mid_reset();
         end else begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rand_target());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
